// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate truth-table sweeper: reference function codes,
// controller state enum and the legality check for func_sel.
package gate_sweep_pkg;

  localparam logic [2:0] FUNC_AND  = 3'd0;
  localparam logic [2:0] FUNC_OR   = 3'd1;
  localparam logic [2:0] FUNC_XOR  = 3'd2;
  localparam logic [2:0] FUNC_NAND = 3'd3;
  localparam logic [2:0] FUNC_NOR  = 3'd4;
  localparam logic [2:0] FUNC_XNOR = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } state_e;

  function automatic logic func_is_legal(logic [2:0] func);
    return func <= FUNC_XNOR;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for a single-output gate: reduces the whole input
// vector with the selected function. Reserved codes yield 0.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 2
) (
  input  logic [2:0]      func,
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  always_comb begin
    expected = 1'b0;
    case (func)
      FUNC_AND:  expected = &vec;
      FUNC_OR:   expected = |vec;
      FUNC_XOR:  expected = ^vec;
      FUNC_NAND: expected = ~&vec;
      FUNC_NOR:  expected = ~|vec;
      FUNC_XNOR: expected = ~^vec;
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sequencer: steps dut_in through every vector, waits
// SETTLE cycles per vector, then compares dut_out against the reference.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func_sel,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LastVec = '1;

  state_e          state_q;
  logic [2:0]      func_q;
  logic [CntW-1:0] cnt_q;
  logic            expected;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  gate_ref_model #(
    .N_IN(N_IN)
  ) u_ref (
    .func    (func_q),
    .vec     (dut_in),
    .expected(expected)
  );

  always_comb begin
    mismatch = dut_out != expected;
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      func_q           <= '0;
      cnt_q            <= '0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            func_q           <= func_sel;
            cnt_q            <= '0;
            dut_in           <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            // Reserved codes finish immediately with pass held low.
            if (func_is_legal(func_sel)) begin
              state_q <= StSettle;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StSettle: begin
          if (cnt_q == CntLast) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCheck: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= dut_in;
          end
          if (dut_in == LastVec) begin
            state_q <= StDone;
            done    <= 1'b1;
            pass    <= err_next == '0;
          end else begin
            dut_in  <= dut_in + 1'b1;
            cnt_q   <= '0;
            state_q <= StSettle;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
